tiled_matmul_accumulator: RTL and testbench

TILED_MATMUL_ACCUMULATOR -- requirements
Module: tiled_matmul_accumulator

---
 rtl/tiled_matmul_accumulator.sv | 205 ++++++++++++++++++++
 tb/tb_tiled_matmul_accumulator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiled_matmul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tiled_matmul_accumulator
//  Description : Accumulates D = C + sum_t A_t * B_t over a job of
//                num_tiles_i tiles, one tile per input handshake. The result
//                is presented through a valid/ready output handshake. A
//                sticky flag reports signed overflow of the accumulator.
//                Optional build macro TILED_MAC_SATURATE_EN selects saturating
//                accumulation; without it, elements wrap modulo 2^ACC_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiled_matmul_accumulator #(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int K          = 2,
    parameter int P          = 8,
    parameter int TILE_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic signed [P-1:0]     A [M][K],
    input  logic signed [P-1:0]     B [K][N],
    input  logic signed [4*P-1:0]   C [M][N],
    input  logic [TILE_CNT_W-1:0]   num_tiles_i,
    output logic signed [4*P-1:0]   D [M][N],
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int c_ACC_W  = 4 * P;
    localparam int c_PROD_W = 2 * P;
    // Base plus K products can never exceed this width, so the sum is exact.
    localparam int c_WIDE_W = c_ACC_W + K + 1;
    localparam int c_TOP_W  = c_WIDE_W - c_ACC_W + 1;

    localparam logic [TILE_CNT_W-1:0] c_CNT_ONE  = TILE_CNT_W'(1);
    localparam logic [TILE_CNT_W-1:0] c_CNT_ZERO = '0;

`ifdef TILED_MAC_SATURATE_EN
    localparam logic signed [c_ACC_W-1:0] c_ACC_MAX = {1'b0, {(c_ACC_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_ACC_MIN = {1'b1, {(c_ACC_W-1){1'b0}}};
`endif

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_OUT   = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_next;
    logic signed [c_ACC_W-1:0]   r_acc [M][N];
    logic [TILE_CNT_W-1:0]       r_count;
    logic [TILE_CNT_W-1:0]       r_target;
    logic                        r_ovf;

    logic signed [c_PROD_W-1:0]  w_prod     [M][N][K];
    logic signed [c_ACC_W-1:0]   w_acc_next [M][N];
    logic                        w_ovf_any;
    logic                        w_accept;
    logic                        w_last_beat;
    logic [TILE_CNT_W-1:0]       w_target_in;

    assign w_accept    = valid_in & ready_in;
    // A tile count of zero is treated as a one-tile job.
    assign w_target_in = (num_tiles_i == c_CNT_ZERO) ? c_CNT_ONE : num_tiles_i;

    // Last beat: single-tile job in IDLE, or the beat that reaches the target in ACCUM.
    always_comb begin
        w_last_beat = 1'b0;
        case (r_state)
            c_IDLE:  w_last_beat = (w_target_in == c_CNT_ONE);
            c_ACCUM: w_last_beat = ((r_count + c_CNT_ONE) == r_target);
            default: w_last_beat = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_last_beat ? c_OUT : c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (w_accept && w_last_beat) begin
                    w_state_next = c_OUT;
                end
            end
            c_OUT: begin
                if (ready_out) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready_in  = (r_state != c_OUT);
        valid_out = (r_state == c_OUT);
        busy_o    = (r_state != c_IDLE);
    end

    // Full-precision signed products of every A row / B column pair.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < K; k++) begin
                    w_prod[i][j][k] = c_PROD_W'(A[i][k]) * c_PROD_W'(B[k][j]);
                end
            end
        end
    end

    // Wide element sums with range check; the first beat of a job starts from C.
    always_comb begin
        logic signed [c_WIDE_W-1:0] w_sum;
        logic [c_TOP_W-1:0]         w_top;
        w_ovf_any = 1'b0;
        w_sum     = '0;
        w_top     = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                w_sum = (r_state == c_IDLE) ? c_WIDE_W'(C[i][j]) : c_WIDE_W'(r_acc[i][j]);
                for (int k = 0; k < K; k++) begin
                    w_sum = w_sum + c_WIDE_W'(w_prod[i][j][k]);
                end
                // In range only if all bits above the ACC_W sign bit copy it.
                w_top = w_sum[c_WIDE_W-1:c_ACC_W-1];
                w_acc_next[i][j] = w_sum[c_ACC_W-1:0];
                if (!((&w_top) || (~|w_top))) begin
                    w_ovf_any = 1'b1;
`ifdef TILED_MAC_SATURATE_EN
                    w_acc_next[i][j] = w_sum[c_WIDE_W-1] ? c_ACC_MIN : c_ACC_MAX;
`endif
                end
            end
        end
    end

    // Accumulator, beat counter, target and sticky overflow update on each accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= '0;
                end
            end
            r_count  <= '0;
            r_target <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                c_IDLE: begin
                    for (int i = 0; i < M; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_acc[i][j] <= w_acc_next[i][j];
                        end
                    end
                    r_count  <= c_CNT_ONE;
                    r_target <= w_target_in;
                    r_ovf    <= w_ovf_any;
                end
                c_ACCUM: begin
                    for (int i = 0; i < M; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_acc[i][j] <= w_acc_next[i][j];
                        end
                    end
                    r_count <= r_count + c_CNT_ONE;
                    r_ovf   <= r_ovf | w_ovf_any;
                end
                default: ;
            endcase
        end
    end

    // Result is the registered accumulator; it only changes on accepted beats.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                D[i][j] = r_acc[i][j];
            end
        end
    end

    assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tiled_matmul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiled_matmul_accumulator
//  Description : Scoreboard bench for tiled_matmul_accumulator (M=N=K=2, P=8).
//                Build with TILED_MAC_SATURATE_EN to match a saturating DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiled_matmul_accumulator;

    localparam longint c_MAXV = 64'sd2147483647;
    localparam longint c_MINV = -64'sd2147483648;

    typedef struct packed {
        logic [3:0][31:0] d;
        logic             ovf;
    } exp_t;

    logic              clk_i;
    logic              rst_ni;
    logic              valid_in;
    logic              ready_in;
    logic signed [7:0] A [2][2];
    logic signed [7:0] B [2][2];
    logic signed [31:0] C [2][2];
    logic [7:0]        num_tiles_i;
    logic signed [31:0] D [2][2];
    logic              valid_out;
    logic              ready_out;
    logic              overflow_o;
    logic              busy_o;
    logic [3:0][31:0]  d_flat;

    int     vectors;
    int     miscompares;
    exp_t   sb [$];
    longint m_acc [4];
    bit     m_ovf;

    tiled_matmul_accumulator #(
        .M(2), .N(2), .K(2), .P(8), .TILE_CNT_W(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .A           (A),
        .B           (B),
        .C           (C),
        .num_tiles_i (num_tiles_i),
        .D           (D),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    assign d_flat = {D[1][1], D[1][0], D[0][1], D[0][0]};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: pop and compare whenever an output handshake is about to occur.
    always @(negedge clk_i) begin
        exp_t e;
        #1;
        if (rst_ni && valid_out && ready_out) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: D=%h ovf=%b with nothing expected", d_flat, overflow_o);
            end else begin
                e = sb.pop_front();
                if (d_flat !== e.d || overflow_o !== e.ovf) begin
                    miscompares++;
                    $display("FAIL result: D=%h ovf=%b expected D=%h ovf=%b", d_flat, overflow_o, e.d, e.ovf);
                end
            end
        end
    end

    task automatic set_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
        A[0][0] = 8'(a00); A[0][1] = 8'(a01); A[1][0] = 8'(a10); A[1][1] = 8'(a11);
        B[0][0] = 8'(b00); B[0][1] = 8'(b01); B[1][0] = 8'(b10); B[1][1] = 8'(b11);
    endtask

    task automatic set_c(input int c00, c01, c10, c11);
        C[0][0] = c00; C[0][1] = c01; C[1][0] = c10; C[1][1] = c11;
    endtask

    // Reference model of one accepted beat.
    task automatic model_beat(input bit first);
        longint w;
        bit     ov_any;
        ov_any = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                w = first ? longint'(C[i][j]) : m_acc[i*2+j];
                for (int k = 0; k < 2; k++) begin
                    w = w + longint'(A[i][k]) * longint'(B[k][j]);
                end
                if (w > c_MAXV || w < c_MINV) begin
                    ov_any = 1'b1;
`ifdef TILED_MAC_SATURATE_EN
                    w = (w > c_MAXV) ? c_MAXV : c_MINV;
`else
                    w = longint'(int'(w));
`endif
                end
                m_acc[i*2+j] = w;
            end
        end
        m_ovf = first ? ov_any : (m_ovf | ov_any);
    endtask

    // Present one beat (called at a negedge); returns cycles spent waiting for ready_in.
    task automatic drive_beat(input bit first, input int nt, input bit last, output int waits);
        exp_t e;
        valid_in    = 1'b1;
        num_tiles_i = 8'(nt);
        waits       = 0;
        while (ready_in !== 1'b1 && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        if (ready_in !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_in_timeout: ready_in=%b expected 1", ready_in);
        end
        model_beat(first);
        if (last) begin
            for (int x = 0; x < 4; x++) e.d[x] = m_acc[x][31:0];
            e.ovf = m_ovf;
            sb.push_back(e);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk_i);
    endtask

    // Whole job with optional idle gaps between beats; checks gaps and one-cycle latency.
    task automatic run_job(input int nt, input int gap);
        int beats;
        int w;
        beats = (nt == 0) ? 1 : nt;
        for (int t = 0; t < beats; t++) begin
            if (t > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk_i);
                    vectors++;
                    if (ready_in !== 1'b1 || busy_o !== 1'b1 || valid_out !== 1'b0) begin
                        miscompares++;
                        $display("FAIL gap_state: ready_in=%b busy=%b valid_out=%b expected 1 1 0",
                                 ready_in, busy_o, valid_out);
                    end
                end
            end
            drive_beat(t == 0, nt, t == beats - 1, w);
        end
        vectors++;
        if (valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: valid_out=%b expected 1 one cycle after last beat", valid_out);
        end
        wait_drain();
    endtask

    task automatic test_reset();
        vectors++;
        if (valid_out !== 1'b0 || busy_o !== 1'b0 || ready_in !== 1'b1 ||
            overflow_o !== 1'b0 || d_flat !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid_out=%b busy=%b ready_in=%b ovf=%b D=%h expected 0 0 1 0 0",
                     valid_out, busy_o, ready_in, overflow_o, d_flat);
        end
    endtask

    task automatic test_single();
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        set_c(0, 0, 0, 0);
        run_job(1, 0);
    endtask

    task automatic test_gapped();
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        set_c(10, 10, 10, 10);
        run_job(3, 2);
    endtask

    task automatic test_stall();
        int w;
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        set_c(0, 0, 0, 0);
        ready_out = 1'b0;
        drive_beat(1'b1, 1, 1'b1, w);
        set_ab(2, 0, 0, 2, 1, 1, 1, 1);
        set_c(5, 5, 5, 5);
        num_tiles_i = 8'd1;
        valid_in    = 1'b1;
        for (int s = 0; s < 5; s++) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL stall_queue: no pending result, expected 1");
            end else if (valid_out !== 1'b1 || ready_in !== 1'b0 ||
                         d_flat !== sb[0].d || overflow_o !== sb[0].ovf) begin
                miscompares++;
                $display("FAIL stall_hold: valid_out=%b ready_in=%b D=%h ovf=%b expected 1 0 %h %b",
                         valid_out, ready_in, d_flat, overflow_o, sb[0].d, sb[0].ovf);
            end
            @(negedge clk_i);
        end
        ready_out = 1'b1;
        drive_beat(1'b1, 1, 1'b1, w);
        vectors++;
        if (w != 1) begin
            miscompares++;
            $display("FAIL stall_release: beat accepted after %0d cycles, expected 1", w);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        set_ab(-3, 4, 7, -8, 9, -10, 11, 12);
        set_c(100, -100, 1000, -1000);
        drive_beat(1'b1, 1, 1'b1, w);
        set_ab(127, -128, -128, 127, -128, 127, 127, -128);
        set_c(-5, 6, -7, 8);
        drive_beat(1'b1, 1, 1'b1, w);
        vectors++;
        if (w != 1) begin
            miscompares++;
            $display("FAIL back_to_back_gap: ready_in low for %0d cycles, expected 1", w);
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        int w;
        set_ab(1, 1, 1, 1, 1, 1, 1, 1);
        set_c(32'h7fffffff, 0, 0, 0);
        run_job(1, 0);
        // Underflow on the first beat, then push back up on the second.
        set_ab(-1, -1, -1, -1, 1, 1, 1, 1);
        set_c(32'h80000000, 0, 0, 0);
        drive_beat(1'b1, 2, 1'b0, w);
        set_ab(1, 1, 1, 1, 1, 1, 1, 1);
        drive_beat(1'b0, 2, 1'b1, w);
        vectors++;
        if (valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_latency: valid_out=%b expected 1", valid_out);
        end
        wait_drain();
    endtask

    task automatic test_reset_midjob();
        int w;
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        set_c(1, 2, 3, 4);
        drive_beat(1'b1, 4, 1'b0, w);
        drive_beat(1'b0, 4, 1'b0, w);
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if (valid_out !== 1'b0 || busy_o !== 1'b0 || ready_in !== 1'b1 || d_flat !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid_out=%b busy=%b ready_in=%b D=%h expected 0 0 1 0",
                     valid_out, busy_o, ready_in, d_flat);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk_i);
            vectors++;
            if (valid_out !== 1'b0 || busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL abandoned_job: valid_out=%b busy=%b expected 0 0", valid_out, busy_o);
            end
        end
        set_ab(2, -3, 4, 5, -6, 7, 8, 9);
        set_c(-20, 30, -40, 50);
        run_job(0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        valid_in    = 1'b0;
        ready_out   = 1'b1;
        num_tiles_i = 8'd0;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        set_c(0, 0, 0, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_single();
        test_gapped();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_midjob();
        repeat (3) @(negedge clk_i);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d results never produced, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
